// File: rtl/accum_stream_feeder.sv
// ---------------------------------------------------------------------------
// accum_stream_feeder
//
// Upstream feeder for the FP16 AXI-stream accumulator. A start request
// captures a base address and an element count. The block then reads that
// many words from a synchronous memory and streams them back-to-back on an
// AXI-stream master, with tlast on the final word. The downstream
// accumulator has no tready, so once a frame is issued nothing ever stalls.
// A zero-length request still produces exactly one 0.0 beat with tlast, so
// the accumulator always closes a frame and returns 0.0.
//
// Parameters
//   DATA_W  element width (FP16 bit pattern, passed through untouched)
//   ADDR_W  memory address width; addresses wrap modulo 2**ADDR_W
//   RD_LAT  memory read latency in cycles (>= 1)
//
// Ports
//   aclk           clock; all logic runs on the rising edge
//   aresetn        asynchronous active-low reset
//   start          frame request, only looked at while idle
//   base_addr      first element address, captured with start
//   length         element count 0..2**ADDR_W, captured with start
//   busy           high from the cycle after an accepted start through done
//   done           one-cycle pulse in the cycle after the tlast beat
//   mem_rd_en      memory read strobe
//   mem_addr       memory read address
//   mem_rd_data    memory read data, valid RD_LAT cycles after a read
//   m_axis_tvalid  beat valid
//   m_axis_tdata   beat data
//   m_axis_tlast   last beat of the frame
// ---------------------------------------------------------------------------
module accum_stream_feeder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ZERO  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t state;
  state_t state_next;

  // Reads still to be issued in the current frame, including the one being
  // issued this cycle. One bit wider than the address so a full-memory
  // frame (2**ADDR_W elements) fits.
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] addr_q;
  logic              issue_last;

  // Tag entering the pipeline alongside each read (or the synthetic zero beat)
  logic tag_in_valid;
  logic tag_in_last;
  logic tag_in_zero;

  // Tag pipeline: one stage per cycle of memory latency, so the tag leaving
  // the last stage lines up with the matching mem_rd_data.
  logic [RD_LAT-1:0] tag_valid;
  logic [RD_LAT-1:0] tag_last;
  logic [RD_LAT-1:0] tag_zero;

  assign issue_last = (remaining == CNT_ONE);
  assign mem_addr   = addr_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    busy         = 1'b0;
    done         = 1'b0;
    mem_rd_en    = 1'b0;
    tag_in_valid = 1'b0;
    tag_in_last  = 1'b0;
    tag_in_zero  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (length == '0) ? ZERO : ISSUE;
        end
      end
      ISSUE: begin
        busy         = 1'b1;
        mem_rd_en    = 1'b1;
        tag_in_valid = 1'b1;
        tag_in_last  = issue_last;
        if (issue_last) begin
          state_next = DRAIN;
        end
      end
      ZERO: begin
        // No memory access; push a tag that forces a 0.0 beat, timed
        // exactly like a single-element frame.
        busy         = 1'b1;
        tag_in_valid = 1'b1;
        tag_in_last  = 1'b1;
        tag_in_zero  = 1'b1;
        state_next   = DRAIN;
      end
      DRAIN: begin
        // The last tag is always still in flight on entry, so waiting for
        // it to show up in the output register is unambiguous.
        busy = 1'b1;
        if (m_axis_tvalid && m_axis_tlast) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Read counter and address. The address is only loaded for non-empty
  // frames and is not advanced past the final read, so outside ISSUE it
  // keeps showing the last address actually read.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      remaining <= '0;
      addr_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (length != '0)) begin
            remaining <= length;
            addr_q    <= base_addr;
          end
        end
        ISSUE: begin
          remaining <= remaining - CNT_ONE;
          if (!issue_last) begin
            addr_q <= addr_q + ADDR_ONE;
          end
        end
        default: begin
          remaining <= remaining;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tag_valid <= '0;
      tag_last  <= '0;
      tag_zero  <= '0;
    end else begin
      tag_valid[0] <= tag_in_valid;
      tag_last[0]  <= tag_in_last;
      tag_zero[0]  <= tag_in_zero;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
        tag_zero[i]  <= tag_zero[i-1];
      end
    end
  end

  // Registered stream outputs: no combinational path from mem_rd_data to
  // the AXI-stream port. tdata only loads on a valid tag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      m_axis_tvalid <= tag_valid[RD_LAT-1];
      m_axis_tlast  <= tag_valid[RD_LAT-1] & tag_last[RD_LAT-1];
      if (tag_valid[RD_LAT-1]) begin
        m_axis_tdata <= tag_zero[RD_LAT-1] ? '0 : mem_rd_data;
      end
    end
  end

endmodule
